// File: rtl/hit_edge_collector.sv
// hit_edge_collector: counts overlaps between object A and object B over each
// video frame, ORs A's hit-edge codes on those pixels, and at the frame boundary
// emits at most one collision pulse, followed by a frame-based cooldown.
module hit_edge_collector #(
    parameter int MIN_OVERLAP     = 4,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int COUNT_W         = 12
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               enable,
    input  logic               startOfFrame,
    input  logic               drawingRequest_A,
    input  logic [3:0]         HitEdgeCode_A,
    input  logic               drawingRequest_B,
    output logic               collision,
    output logic [3:0]         collisionEdge,
    output logic [COUNT_W-1:0] lastOverlapCount,
    output logic               busy
);

    // The cooldown counter needs at least one bit, even when cooldown is disabled.
    localparam int CD_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    localparam logic [CD_W-1:0]    CD_LOAD   = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0]    CD_ONE    = CD_W'(1);
    localparam logic [COUNT_W-1:0] MIN_OVL   = COUNT_W'(MIN_OVERLAP);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SCAN,
        COOLDOWN
    } state_t;

    state_t             state, state_nxt;
    logic [COUNT_W-1:0] count, count_nxt;
    logic [3:0]         edge_acc, edge_acc_nxt;
    logic [CD_W-1:0]    cooldown_cnt, cooldown_cnt_nxt;
    logic               collision_nxt;
    logic [3:0]         collision_edge_nxt;
    logic [COUNT_W-1:0] last_count_nxt;
    logic               busy_nxt;

    logic               ovl;
    logic [COUNT_W-1:0] count_inc;
    logic [COUNT_W-1:0] count_fresh;
    logic [3:0]         edge_fresh;
    logic               frame_hit;

    // Overlap and the values a new frame starts with; the boundary pixel belongs to the new frame.
    always_comb begin
        ovl         = drawingRequest_A & drawingRequest_B;
        count_inc   = (count == COUNT_MAX) ? count : count + 1'b1;
        count_fresh = {{(COUNT_W-1){1'b0}}, ovl};
        edge_fresh  = ovl ? HitEdgeCode_A : 4'h0;
        frame_hit   = (count >= MIN_OVL);
    end

    // Next-state and next-output logic; disable overrides every state.
    always_comb begin
        state_nxt          = state;
        count_nxt          = count;
        edge_acc_nxt       = edge_acc;
        cooldown_cnt_nxt   = cooldown_cnt;
        collision_nxt      = 1'b0;
        collision_edge_nxt = collisionEdge;
        last_count_nxt     = lastOverlapCount;

        if (!enable) begin
            state_nxt        = IDLE;
            count_nxt        = '0;
            edge_acc_nxt     = 4'h0;
            cooldown_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SYNC;
                end

                SYNC: begin
                    if (startOfFrame) begin
                        state_nxt    = SCAN;
                        count_nxt    = '0;
                        edge_acc_nxt = 4'h0;
                    end
                end

                SCAN: begin
                    if (startOfFrame) begin
                        last_count_nxt = count;
                        count_nxt      = count_fresh;
                        edge_acc_nxt   = edge_fresh;
                        if (frame_hit) begin
                            collision_nxt      = 1'b1;
                            collision_edge_nxt = edge_acc;
                            if (COOLDOWN_FRAMES > 0) begin
                                state_nxt        = COOLDOWN;
                                cooldown_cnt_nxt = CD_LOAD;
                                count_nxt        = '0;
                                edge_acc_nxt     = 4'h0;
                            end
                        end
                    end else if (ovl) begin
                        count_nxt    = count_inc;
                        edge_acc_nxt = edge_acc | HitEdgeCode_A;
                    end
                end

                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cooldown_cnt <= CD_ONE) begin
                            state_nxt        = SCAN;
                            cooldown_cnt_nxt = '0;
                            count_nxt        = count_fresh;
                            edge_acc_nxt     = edge_fresh;
                        end else begin
                            cooldown_cnt_nxt = cooldown_cnt - 1'b1;
                        end
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt == COOLDOWN);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= IDLE;
            count            <= '0;
            edge_acc         <= 4'h0;
            cooldown_cnt     <= '0;
            collision        <= 1'b0;
            collisionEdge    <= 4'h0;
            lastOverlapCount <= '0;
            busy             <= 1'b0;
        end else begin
            state            <= state_nxt;
            count            <= count_nxt;
            edge_acc         <= edge_acc_nxt;
            cooldown_cnt     <= cooldown_cnt_nxt;
            collision        <= collision_nxt;
            collisionEdge    <= collision_edge_nxt;
            lastOverlapCount <= last_count_nxt;
            busy             <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_hit_edge_collector.sv
// tb_hit_edge_collector: directed bench for hit_edge_collector with the default
// parameters (MIN_OVERLAP=4, COOLDOWN_FRAMES=2, COUNT_W=12).
module tb_hit_edge_collector;

    logic        clk;
    logic        resetN;
    logic        enable;
    logic        startOfFrame;
    logic        drawingRequest_A;
    logic [3:0]  HitEdgeCode_A;
    logic        drawingRequest_B;
    logic        collision;
    logic [3:0]  collisionEdge;
    logic [11:0] lastOverlapCount;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          full;
        logic        coll;
        logic [3:0]  edg;
        logic [11:0] last;
        logic        bsy;
        string       tag;
    } exp_t;

    exp_t sb[$];

    hit_edge_collector #(
        .MIN_OVERLAP(4),
        .COOLDOWN_FRAMES(2),
        .COUNT_W(12)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .enable(enable),
        .startOfFrame(startOfFrame),
        .drawingRequest_A(drawingRequest_A),
        .HitEdgeCode_A(HitEdgeCode_A),
        .drawingRequest_B(drawingRequest_B),
        .collision(collision),
        .collisionEdge(collisionEdge),
        .lastOverlapCount(lastOverlapCount),
        .busy(busy)
    );

    // Free-running pixel clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue what the DUT must show after the edge, then pop and compare.
    task automatic applyStimulus(input logic sof, input logic a, input logic b, input logic [3:0] code,
                                 input string tag, input bit full, input logic ecoll,
                                 input logic [3:0] eedge, input logic [11:0] elast, input logic ebusy);
        exp_t e;
        startOfFrame     = sof;
        drawingRequest_A = a;
        drawingRequest_B = b;
        HitEdgeCode_A    = code;
        e.full = full;
        e.coll = ecoll;
        e.edg  = eedge;
        e.last = elast;
        e.bsy  = ebusy;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput({e.tag, ".collision"}, 32'(collision), 32'(e.coll));
        if (e.full) begin
            checkOutput({e.tag, ".collisionEdge"}, 32'(collisionEdge), 32'(e.edg));
            checkOutput({e.tag, ".lastOverlapCount"}, 32'(lastOverlapCount), 32'(e.last));
            checkOutput({e.tag, ".busy"}, 32'(busy), 32'(e.bsy));
        end
        startOfFrame = 1'b0;
    endtask

    task automatic run(input int n, input logic a, input logic b, input logic [3:0] code);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, a, b, code, "run", 1'b0, 1'b0, 4'h0, 12'h0, 1'b0);
    endtask

    task automatic sofStep(input logic ovl, input logic [3:0] code, input string tag, input logic ecoll,
                           input logic [3:0] eedge, input logic [11:0] elast, input logic ebusy);
        applyStimulus(1'b1, ovl, ovl, code, tag, 1'b1, ecoll, eedge, elast, ebusy);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".collision"}, 32'(collision), 32'h0);
        checkOutput({tag, ".collisionEdge"}, 32'(collisionEdge), 32'h0);
        checkOutput({tag, ".lastOverlapCount"}, 32'(lastOverlapCount), 32'h0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    // Directed sequence of steps.
    initial begin
        resetN           = 1'b0;
        enable           = 1'b0;
        startOfFrame     = 1'b0;
        drawingRequest_A = 1'b0;
        drawingRequest_B = 1'b0;
        HitEdgeCode_A    = 4'h0;

        #3;
        checkAllZero("reset");
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        run(2, 1'b0, 1'b0, 4'h0);

        $display("[TB] first report with mixed A-only/B-only pixels");
        enable = 1'b1;
        run(1, 1'b0, 1'b0, 4'h0);
        run(3, 1'b1, 1'b1, 4'hF);
        sofStep(1'b0, 4'h0, "sync_sof", 1'b0, 4'h0, 12'd0, 1'b0);
        run(1, 1'b1, 1'b1, 4'h8);
        run(2, 1'b1, 1'b0, 4'h1);
        run(1, 1'b1, 1'b1, 4'h8);
        run(1, 1'b1, 1'b1, 4'hC);
        run(2, 1'b0, 1'b1, 4'h2);
        run(1, 1'b1, 1'b1, 4'h4);
        run(1, 1'b1, 1'b1, 4'h4);
        sofStep(1'b0, 4'h0, "rep1", 1'b1, 4'hC, 12'd5, 1'b1);

        $display("[TB] cooldown frames ignore overlaps");
        run(10, 1'b1, 1'b1, 4'hF);
        sofStep(1'b0, 4'h0, "cd1", 1'b0, 4'hC, 12'd5, 1'b1);
        run(10, 1'b1, 1'b1, 4'hF);
        sofStep(1'b0, 4'h0, "cd2", 1'b0, 4'hC, 12'd5, 1'b0);
        run(4, 1'b1, 1'b1, 4'h1);
        sofStep(1'b0, 4'h0, "rep2", 1'b1, 4'h1, 12'd4, 1'b1);
        run(3, 1'b0, 1'b0, 4'h0);
        sofStep(1'b0, 4'h0, "cd3", 1'b0, 4'h1, 12'd4, 1'b1);
        run(3, 1'b0, 1'b0, 4'h0);
        sofStep(1'b0, 4'h0, "cd4", 1'b0, 4'h1, 12'd4, 1'b0);

        $display("[TB] below threshold, then overlap on the boundary pixel");
        run(3, 1'b1, 1'b1, 4'h2);
        sofStep(1'b1, 4'h1, "short", 1'b0, 4'h1, 12'd3, 1'b0);
        run(3, 1'b1, 1'b1, 4'h2);
        sofStep(1'b0, 4'h0, "coinc", 1'b1, 4'h3, 12'd4, 1'b1);
        run(2, 1'b0, 1'b0, 4'h0);
        sofStep(1'b0, 4'h0, "cd5", 1'b0, 4'h3, 12'd4, 1'b1);
        run(2, 1'b0, 1'b0, 4'h0);
        sofStep(1'b0, 4'h0, "cd6", 1'b0, 4'h3, 12'd4, 1'b0);

        $display("[TB] counter saturation");
        run(5000, 1'b1, 1'b1, 4'h8);
        sofStep(1'b0, 4'h0, "sat", 1'b1, 4'h8, 12'd4095, 1'b1);

        $display("[TB] disable during cooldown and mid-frame");
        run(1, 1'b0, 1'b0, 4'h0);
        enable = 1'b0;
        run(1, 1'b0, 1'b0, 4'h0);
        checkOutput("dis_cooldown.busy", 32'(busy), 32'h0);
        enable = 1'b1;
        run(1, 1'b0, 1'b0, 4'h0);
        sofStep(1'b0, 4'h0, "resync", 1'b0, 4'h8, 12'd4095, 1'b0);
        run(6, 1'b1, 1'b1, 4'h4);
        enable = 1'b0;
        sofStep(1'b0, 4'h0, "dis_sof", 1'b0, 4'h8, 12'd4095, 1'b0);
        run(3, 1'b1, 1'b1, 4'h4);
        sofStep(1'b0, 4'h0, "dis_sof2", 1'b0, 4'h8, 12'd4095, 1'b0);
        enable = 1'b1;
        run(1, 1'b0, 1'b0, 4'h0);
        sofStep(1'b0, 4'h0, "resync2", 1'b0, 4'h8, 12'd4095, 1'b0);

        $display("[TB] asynchronous reset mid-scan");
        run(3, 1'b1, 1'b1, 4'h4);
        resetN = 1'b0;
        #2;
        checkAllZero("mid_reset");
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        run(1, 1'b0, 1'b0, 4'h0);
        run(4, 1'b1, 1'b1, 4'hF);
        sofStep(1'b0, 4'h0, "post_rst_sof", 1'b0, 4'h0, 12'd0, 1'b0);
        run(4, 1'b1, 1'b1, 4'h2);
        sofStep(1'b0, 4'h0, "rep_final", 1'b1, 4'h2, 12'd4, 1'b1);
        run(1, 1'b0, 1'b0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_edge_collector.md
Name: hit_edge_collector

Overview:
- Consumer end of the bitmap drawing interface.
- Takes the registered drawingRequest/HitEdgeCode pair from the win/car bitmap (object A) and the drawingRequest from a second object (B, e.g. the player car).
- Counts pixel overlaps over a video frame and ORs the hit-edge codes of the overlapping pixels.
- At each frame boundary, reports at most one debounced collision pulse with the accumulated edge code, then applies a frame-based cooldown.

Parameters:
- MIN_OVERLAP, 4: minimum overlapping pixels in one frame for a collision report.
- COOLDOWN_FRAMES, 2: number of frame boundaries ignored after a report; 0 means no cooldown.
- COUNT_W, 12: width of the overlap counter.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- enable  in  1  collision detection enable.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- drawingRequest_A  in  1  object A pixel is opaque; comes from the bitmap's output register.
- HitEdgeCode_A  in  4  {Left, Top, Right, Bottom} edge code, valid alongside drawingRequest_A.
- drawingRequest_B  in  1  object B pixel is opaque; must be pipeline-aligned with A by the integrator.
- collision  out  1  one-cycle pulse: collision in the frame just ended.
- collisionEdge  out  4  OR of HitEdgeCode_A over that frame's overlap pixels; held until the next report.
- lastOverlapCount  out  COUNT_W  overlap count of the last completed frame scanned in SCAN.
- busy  out  1  high while in COOLDOWN.

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE; collision, collisionEdge, lastOverlapCount, busy all 0.
  - Internal count, edgeAcc and cooldown counter cleared.
- Overlap definition: ovl = drawingRequest_A & drawingRequest_B. It is sampled combinationally; all outputs are registered.
- States:
  - IDLE: on enable=1 go to SYNC next cycle.
  - SYNC: on startOfFrame go to SCAN; count and edgeAcc are cleared. This prevents partial-frame counting.
  - SCAN:
    - Each cycle with ovl=1: count saturating-increments (holds at all-ones); edgeAcc |= HitEdgeCode_A.
    - On startOfFrame: lastOverlapCount <= count.
      - If count >= MIN_OVERLAP: collision=1 for exactly one cycle (the cycle after startOfFrame), collisionEdge <= edgeAcc. Then go to COOLDOWN with cooldown counter = COOLDOWN_FRAMES, or stay in SCAN if COOLDOWN_FRAMES=0.
      - Else: no pulse, collisionEdge held.
    - count/edgeAcc restart for the new frame. An ovl on the same cycle as startOfFrame belongs to the new frame (count=1, edgeAcc=that code).
  - COOLDOWN:
    - busy=1; ovl ignored.
    - Each startOfFrame decrements the counter. The startOfFrame on which it reaches 0 moves to SCAN and begins a fresh frame (count/edgeAcc cleared, ovl on that cycle counted).
- Latency: the report appears one clock after startOfFrame.
- Disable: enable=0 in any state → IDLE next cycle.
  - count, edgeAcc and cooldown are cleared; collision forced 0; busy 0.
  - collisionEdge and lastOverlapCount are held.
  - A startOfFrame on the same cycle as enable falling produces no report.
- Arithmetic: comparison count >= MIN_OVERLAP is unsigned on COUNT_W bits. MIN_OVERLAP=0 reports every scanned frame, including frames with zero overlaps (edge 0).
- At most one collision pulse per frame. collision is never asserted outside SCAN→report transitions.

Test Plan:
- Reset mid-SCAN with count=3 → all outputs 0 immediately; after release with enable=1, no counting until the first startOfFrame.
- enable=1, SOF, 5 ovl cycles with edges 4'h8,4'h8,4'hC,4'h4,4'h4, then SOF → collision=1 one cycle after SOF; collisionEdge=4'hC; lastOverlapCount=5; busy=1.
- 3 ovl cycles, then SOF (MIN_OVERLAP=4) → no pulse; lastOverlapCount=3; collisionEdge unchanged; state stays SCAN.
- After a report with COOLDOWN_FRAMES=2: 10 ovl cycles in each of the next 2 frames → no pulse; busy drops on the 2nd SOF; the following frame with 4 ovl cycles → pulse.
- SOF coincident with ovl (edge 4'h1), plus 3 more ovl (edge 4'h2), then SOF → pulse; collisionEdge=4'h3; lastOverlapCount=4.
- Hold ovl=1 for 5000 cycles with COUNT_W=12 → lastOverlapCount=4095 (saturated); enable=0 mid-frame → next SOF gives no pulse, and collisionEdge is held.
